instr_fetch: RTL and testbench

//  Instruction fetch stage feeding the single-cycle controller/datapath pair.

---
 rtl/instr_fetch_if.sv | 21 ++
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction handshake bundle between the fetch stage and the controller/datapath.
// The master drives the registered instruction and its valid flag; the slave returns ready.
interface instr_fetch_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable instruction memory plus PC, presenting one registered
// instruction per accepted cycle and stopping when a HALT opcode is reached.
module instr_fetch #(
    parameter int         DEPTH   = 64,
    parameter int         ADDR_W  = 6,
    parameter int         DATA_W  = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    instr_fetch_if.master     o_fetch,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_nextPc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] w_nextInstr;
    logic              r_valid;
    logic              w_nextValid;
    logic              r_halted;
    logic              w_nextHalted;
    logic [DATA_W-1:0] w_word;
    logic              w_isHalt;
    logic              w_load;

    assign w_word   = r_mem[r_pc];
    assign w_isHalt = (w_word[DATA_W-1 -: 6] == HALT_OP);
    assign w_load   = !r_valid || o_fetch.instr_ready;

    // Program writes are locked out while fetching so the running program cannot change underneath.
    always_ff @(posedge i_clk) begin
        if (i_prog_we && (r_state != RUN)) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_pc     <= w_nextPc;
            r_instr  <= w_nextInstr;
            r_valid  <= w_nextValid;
            r_halted <= w_nextHalted;
        end
    end

    // A HALT word is never presented downstream; PC stays on it so software can see where fetch stopped.
    always_comb begin
        w_nextState  = r_state;
        w_nextPc     = r_pc;
        w_nextInstr  = r_instr;
        w_nextValid  = r_valid;
        w_nextHalted = r_halted;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = RUN;
                    w_nextPc    = '0;
                end
            end
            RUN: begin
                if (w_load) begin
                    if (w_isHalt) begin
                        w_nextValid  = 1'b0;
                        w_nextHalted = 1'b1;
                        w_nextState  = HALT;
                    end else begin
                        w_nextInstr = w_word;
                        w_nextValid = 1'b1;
                        w_nextPc    = r_pc + 1'b1;
                    end
                end
            end
            HALT: begin
                w_nextValid = 1'b0;
                if (i_start) begin
                    w_nextState  = RUN;
                    w_nextPc     = '0;
                    w_nextHalted = 1'b0;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign o_fetch.instr       = r_instr;
    assign o_fetch.instr_valid = r_valid;
    assign o_pc                = r_pc;
    assign o_halted            = r_halted;
    assign o_busy              = (r_state == RUN);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch using a 16-word memory so PC wrap-around is reachable.
// Each scenario task drives its own stimulus and checks results against hand-computed values.
module tb_instr_fetch;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    localparam logic [31:0] LW1  = 32'h8C01_0001;
    localparam logic [31:0] LW2  = 32'h8C22_0001;
    localparam logic [31:0] ADDI = 32'h0001_1820;
    localparam logic [31:0] HLT  = 32'hFC00_0000;

    logic              clk;
    logic              rst;
    logic              start;
    logic              progWe;
    logic [ADDR_W-1:0] progAddr;
    logic [DATA_W-1:0] progData;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              busy;

    int nTests;
    int nFail;
    logic [31:0] wrapWords [DEPTH];

    instr_fetch_if #(.DATA_W(DATA_W)) fIf ();

    instr_fetch #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_prog_we  (progWe),
        .i_prog_addr(progAddr),
        .i_prog_data(progData),
        .o_fetch    (fIf.master),
        .o_pc       (pc),
        .o_halted   (halted),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge before anything is checked or driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        progWe   = 1'b1;
        progAddr = a;
        progData = d;
        tick();
        progWe = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nTests++;
        if (fIf.instr !== 32'h0 || fIf.instr_valid !== 1'b0 || pc !== 4'd0 || halted !== 1'b0 || busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset: instr=%h valid=%b pc=%0d halted=%b busy=%b, required 0/0/0/0/0",
                     fIf.instr, fIf.instr_valid, pc, halted, busy);
        end
    endtask

    task automatic test_basic_program();
        logic [31:0] exp [3];
        exp[0] = LW1; exp[1] = LW2; exp[2] = ADDI;
        writeWord(4'd0, LW1);
        writeWord(4'd1, LW2);
        writeWord(4'd2, ADDI);
        writeWord(4'd3, HLT);
        fIf.instr_ready = 1'b1;
        pulseStart();
        nTests++;
        if (busy !== 1'b1 || fIf.instr_valid !== 1'b0 || pc !== 4'd0) begin
            nFail++;
            $display("[TB] FAIL basic_start: busy=%b valid=%b pc=%0d, required 1/0/0", busy, fIf.instr_valid, pc);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            nTests++;
            if (fIf.instr !== exp[k] || fIf.instr_valid !== 1'b1 || pc !== 4'(k + 1)) begin
                nFail++;
                $display("[TB] FAIL basic_issue%0d: instr=%h valid=%b pc=%0d, required %h/1/%0d",
                         k, fIf.instr, fIf.instr_valid, pc, exp[k], k + 1);
            end
        end
        tick();
        nTests++;
        if (fIf.instr_valid !== 1'b0 || halted !== 1'b1 || pc !== 4'd3 || busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL basic_halt: valid=%b halted=%b pc=%0d busy=%b, required 0/1/3/0",
                     fIf.instr_valid, halted, pc, busy);
        end
        tick();
        nTests++;
        if (fIf.instr !== ADDI || fIf.instr_valid !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL halt_hold: instr=%h valid=%b, required %h/0", fIf.instr, fIf.instr_valid, ADDI);
        end
    endtask

    task automatic test_stall();
        doReset();
        fIf.instr_ready = 1'b1;
        pulseStart();
        tick();
        tick();
        fIf.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            nTests++;
            if (fIf.instr !== LW2 || fIf.instr_valid !== 1'b1 || pc !== 4'd2) begin
                nFail++;
                $display("[TB] FAIL stall%0d: instr=%h valid=%b pc=%0d, required %h/1/2",
                         k, fIf.instr, fIf.instr_valid, pc, LW2);
            end
        end
        fIf.instr_ready = 1'b1;
        tick();
        nTests++;
        if (fIf.instr !== ADDI || fIf.instr_valid !== 1'b1 || pc !== 4'd3) begin
            nFail++;
            $display("[TB] FAIL stall_resume: instr=%h valid=%b pc=%0d, required %h/1/3",
                     fIf.instr, fIf.instr_valid, pc, ADDI);
        end
        tick();
        nTests++;
        if (halted !== 1'b1 || fIf.instr_valid !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL stall_halt: halted=%b valid=%b, required 1/0", halted, fIf.instr_valid);
        end
    endtask

    task automatic test_wrap();
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            wrapWords[i] = 32'h0100_0000 + 32'(i * 3 + 7);
            writeWord(4'(i), wrapWords[i]);
        end
        fIf.instr_ready = 1'b1;
        pulseStart();
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            nTests++;
            if (fIf.instr !== wrapWords[k] || pc !== 4'((k + 1) % DEPTH)) begin
                nFail++;
                $display("[TB] FAIL wrap_issue%0d: instr=%h pc=%0d, required %h/%0d",
                         k, fIf.instr, pc, wrapWords[k], (k + 1) % DEPTH);
            end
        end
        tick();
        nTests++;
        if (fIf.instr !== wrapWords[0] || pc !== 4'd1 || halted !== 1'b0 || fIf.instr_valid !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL wrap_around: instr=%h pc=%0d halted=%b valid=%b, required %h/1/0/1",
                     fIf.instr, pc, halted, fIf.instr_valid, wrapWords[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        doReset();
        fIf.instr_ready = 1'b1;
        pulseStart();
        for (int k = 0; k < 5; k++) tick();
        nTests++;
        if (pc !== 4'd5) begin
            nFail++;
            $display("[TB] FAIL midrun_pc: pc=%0d, required 5", pc);
        end
        doReset();
        nTests++;
        if (fIf.instr !== 32'h0 || fIf.instr_valid !== 1'b0 || pc !== 4'd0 || busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL midrun_reset: instr=%h valid=%b pc=%0d busy=%b, required 0/0/0/0",
                     fIf.instr, fIf.instr_valid, pc, busy);
        end
        pulseStart();
        tick();
        nTests++;
        if (fIf.instr !== wrapWords[0] || fIf.instr_valid !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL midrun_restart: instr=%h valid=%b, required %h/1", fIf.instr, fIf.instr_valid, wrapWords[0]);
        end
    endtask

    task automatic test_prog_lockout();
        writeWord(4'd0, 32'hDEAD_BEEF);
        doReset();
        pulseStart();
        tick();
        nTests++;
        if (fIf.instr !== wrapWords[0]) begin
            nFail++;
            $display("[TB] FAIL run_write_ignored: instr=%h, required %h", fIf.instr, wrapWords[0]);
        end
        doReset();
        progWe   = 1'b1;
        progAddr = 4'd0;
        progData = 32'h2222_3333;
        start    = 1'b1;
        tick();
        progWe = 1'b0;
        start  = 1'b0;
        tick();
        nTests++;
        if (fIf.instr !== 32'h2222_3333 || fIf.instr_valid !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL write_with_start: instr=%h valid=%b, required 22223333/1", fIf.instr, fIf.instr_valid);
        end
        doReset();
    endtask

    task automatic test_restart_from_halt();
        int cnt;
        writeWord(4'd0, LW1);
        writeWord(4'd1, LW2);
        writeWord(4'd2, ADDI);
        writeWord(4'd3, HLT);
        writeWord(4'd4, HLT);
        fIf.instr_ready = 1'b1;
        pulseStart();
        for (int k = 0; k < 10 && halted !== 1'b1; k++) tick();
        nTests++;
        if (halted !== 1'b1 || pc !== 4'd3) begin
            nFail++;
            $display("[TB] FAIL restart_first_halt: halted=%b pc=%0d, required 1/3", halted, pc);
        end
        writeWord(4'd3, ADDI);
        pulseStart();
        nTests++;
        if (halted !== 1'b0 || pc !== 4'd0 || busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL restart_start: halted=%b pc=%0d busy=%b, required 0/0/1", halted, pc, busy);
        end
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (halted === 1'b1) break;
            if (fIf.instr_valid === 1'b1) cnt++;
        end
        nTests++;
        if (cnt !== 4 || halted !== 1'b1 || pc !== 4'd4) begin
            nFail++;
            $display("[TB] FAIL restart_count: issued=%0d halted=%b pc=%0d, required 4/1/4", cnt, halted, pc);
        end
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        progWe = 1'b0;
        progAddr = '0;
        progData = '0;
        fIf.instr_ready = 1'b1;
        tick();
        test_reset();
        test_basic_program();
        test_stall();
        test_wrap();
        test_reset_mid_run();
        test_prog_lockout();
        test_restart_from_halt();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
